// File: rtl/cmd_packer_if.sv
// rtl/cmd_packer_if.sv - request, write-data and cmd_fifo push bundle for cmd_packer
// master is the request/data source and FIFO side; slave is the packer itself.
interface cmd_packer_if #(
    parameter int TYPE_WIDTH = 2,
    parameter int ADDR_WIDTH = 27,
    parameter int BRST_WIDTH = 6,
    parameter int DATA_WIDTH = 128,
    parameter int MASK_WIDTH = 16
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_wen;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [BRST_WIDTH-1:0] req_burst_cnt;
    logic                  wd_valid;
    logic                  wd_ready;
    logic [DATA_WIDTH-1:0] wd_data;
    logic [MASK_WIDTH-1:0] wd_mask;
    logic                  wd_last;
    logic                  push_valid;
    logic                  push_ready;
    logic [TYPE_WIDTH-1:0] push_type;
    logic [ADDR_WIDTH-1:0] push_addr;
    logic [BRST_WIDTH-1:0] push_burst_cnt;
    logic [DATA_WIDTH-1:0] push_wt_data;
    logic [MASK_WIDTH-1:0] push_wt_mask;
    logic                  err_len;

    modport master (
        output req_valid, req_wen, req_addr, req_burst_cnt,
        output wd_valid, wd_data, wd_mask, wd_last, push_ready,
        input  req_ready, wd_ready, push_valid, push_type, push_addr,
        input  push_burst_cnt, push_wt_data, push_wt_mask, err_len
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_burst_cnt,
        input  wd_valid, wd_data, wd_mask, wd_last, push_ready,
        output req_ready, wd_ready, push_valid, push_type, push_addr,
        output push_burst_cnt, push_wt_data, push_wt_mask, err_len
    );
endinterface

// File: rtl/cmd_packer.sv
// rtl/cmd_packer.sv - packs read/write requests and write beats into the cmd_fifo push stream
// Optional CMD_PKR_ADDR_INC_EN: each write beat address advances by ADDR_STEP.
module cmd_packer #(
    parameter int TYPE_WIDTH = 2,
    parameter int ADDR_WIDTH = 27,
    parameter int BRST_WIDTH = 6,
    parameter int DATA_WIDTH = 128,
    parameter int MASK_WIDTH = 16,
    parameter int ADDR_STEP  = 8
) (
    input  logic         wt_clk,
    input  logic         rstn,
    cmd_packer_if.slave  bus
);
    localparam logic [TYPE_WIDTH-1:0] TYPE_IDE = TYPE_WIDTH'(0);
    localparam logic [TYPE_WIDTH-1:0] TYPE_WT  = TYPE_WIDTH'(2);
    localparam logic [TYPE_WIDTH-1:0] TYPE_RD  = TYPE_WIDTH'(3);

    typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WT} state_t;

    if (DATA_WIDTH != MASK_WIDTH * 8 || ADDR_STEP < 0) begin : g_bad_cfg
        $error("cmd_packer: MASK_WIDTH must be DATA_WIDTH/8 and ADDR_STEP non-negative");
    end

    state_t                state_q;
    logic                  req_ready_q;
    logic                  push_valid_q;
    logic                  err_len_q;
    logic [TYPE_WIDTH-1:0] push_type_q;
    logic [ADDR_WIDTH-1:0] push_addr_q;
    logic [BRST_WIDTH-1:0] push_burst_q;
    logic [DATA_WIDTH-1:0] push_data_q;
    logic [MASK_WIDTH-1:0] push_mask_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [BRST_WIDTH-1:0] burst_q;
    // One bit wider than the burst field so a 64-beat burst never wraps to 0.
    logic [BRST_WIDTH:0]   beat_cnt_q;

    logic                  all_loaded;
    logic                  final_beat;
    logic                  wd_ready;
    logic                  wd_hs;
    logic                  req_hs;
    logic [ADDR_WIDTH-1:0] beat_addr;

    assign all_loaded = beat_cnt_q > {1'b0, burst_q};
    assign final_beat = beat_cnt_q == {1'b0, burst_q};
    assign wd_ready   = (state_q == ST_WT) && !all_loaded && (!push_valid_q || bus.push_ready);
    assign wd_hs      = bus.wd_valid && wd_ready;
    assign req_hs     = bus.req_valid && req_ready_q;

`ifdef CMD_PKR_ADDR_INC_EN
    assign beat_addr = addr_q + ADDR_WIDTH'(beat_cnt_q) * ADDR_WIDTH'(ADDR_STEP);
`else
    assign beat_addr = addr_q;
`endif

    always_ff @(posedge wt_clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            req_ready_q  <= 1'b0;
            push_valid_q <= 1'b0;
            err_len_q    <= 1'b0;
            push_type_q  <= TYPE_IDE;
            push_addr_q  <= '0;
            push_burst_q <= '0;
            push_data_q  <= '0;
            push_mask_q  <= '1;
            addr_q       <= '0;
            burst_q      <= '0;
            beat_cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    req_ready_q <= 1'b1;
                    if (req_hs) begin
                        req_ready_q <= 1'b0;
                        addr_q      <= bus.req_addr;
                        burst_q     <= bus.req_burst_cnt;
                        beat_cnt_q  <= '0;
                        if (bus.req_wen) begin
                            state_q <= ST_WT;
                        end else begin
                            state_q      <= ST_RD;
                            push_valid_q <= 1'b1;
                            push_type_q  <= TYPE_RD;
                            push_addr_q  <= bus.req_addr;
                            push_burst_q <= bus.req_burst_cnt;
                            push_data_q  <= '0;
                            push_mask_q  <= '1;
                        end
                    end
                end
                ST_RD: begin
                    if (bus.push_ready) begin
                        push_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= ST_IDLE;
                    end
                end
                ST_WT: begin
                    if (wd_hs) begin
                        push_valid_q <= 1'b1;
                        push_type_q  <= TYPE_WT;
                        push_addr_q  <= beat_addr;
                        push_burst_q <= burst_q;
                        push_data_q  <= bus.wd_data;
                        push_mask_q  <= bus.wd_mask;
                        beat_cnt_q   <= beat_cnt_q + 1'b1;
                        if (bus.wd_last != final_beat) begin
                            err_len_q <= 1'b1;
                        end
                    end else if (bus.push_ready) begin
                        push_valid_q <= 1'b0;
                        // Final beat just left the push port: burst complete.
                        if (all_loaded && push_valid_q) begin
                            state_q     <= ST_IDLE;
                            beat_cnt_q  <= '0;
                            req_ready_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready      = req_ready_q;
    assign bus.wd_ready       = wd_ready;
    assign bus.push_valid     = push_valid_q;
    assign bus.push_type      = push_type_q;
    assign bus.push_addr      = push_addr_q;
    assign bus.push_burst_cnt = push_burst_q;
    assign bus.push_wt_data   = push_data_q;
    assign bus.push_wt_mask   = push_mask_q;
    assign bus.err_len        = err_len_q;
endmodule

// File: tb/tb_cmd_packer.sv
// tb/tb_cmd_packer.sv - self-checking bench for cmd_packer
`timescale 1ns/1ps
module tb_cmd_packer;
    localparam int AW = 27;
    localparam int BW = 6;
    localparam int DW = 128;
    localparam int MW = 16;
    localparam logic [DW-1:0] DBASE = 128'h0123456789abcdeffedcba9876543210;

    typedef struct packed {
        logic [1:0]    typ;
        logic [AW-1:0] addr;
        logic [BW-1:0] bc;
        logic [DW-1:0] data;
        logic [MW-1:0] mask;
    } beat_t;

    typedef struct {
        bit            wen;
        logic [AW-1:0] addr;
        logic [BW-1:0] bc;
        int            last_at;
        int            mode;
        int            exp_beats;
    } vec_t;

    logic wt_clk = 1'b0;
    logic rstn   = 1'b0;
    always #5 wt_clk = ~wt_clk;

    cmd_packer_if #(.TYPE_WIDTH(2), .ADDR_WIDTH(AW), .BRST_WIDTH(BW),
                    .DATA_WIDTH(DW), .MASK_WIDTH(MW)) bus ();

    cmd_packer dut (
        .wt_clk (wt_clk),
        .rstn   (rstn),
        .bus    (bus)
    );

    int    checks    = 0;
    int    failures  = 0;
    int    cyc_cnt   = 0;
    int    pr_mode   = 0;
    int    pr_phase  = 0;
    bit    err_model = 1'b0;
    bit    stalled   = 1'b0;
    beat_t stall_snap;
    beat_t mon_cur;
    beat_t exp_q[$];
    beat_t got_q[$];
    vec_t  vecs[7];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [AW-1:0] model_addr(input logic [AW-1:0] a, input int i);
        int step = 8;
`ifndef CMD_PKR_ADDR_INC_EN
        step = 0;
`endif
        return AW'(a + i * step);
    endfunction

    always @(posedge wt_clk) cyc_cnt++;

    // push_ready source: 0 = always ready, 1 = 1,0,0,1 pattern, 2 = random ~70%
    always @(posedge wt_clk) begin
        #1;
        case (pr_mode)
            0:       bus.push_ready = 1'b1;
            1: begin
                bus.push_ready = (pr_phase % 4 == 0) || (pr_phase % 4 == 3);
                pr_phase++;
            end
            default: bus.push_ready = ($urandom_range(0, 9) < 7);
        endcase
    end

    // Push monitor: collects accepted beats and checks stall stability.
    always @(negedge wt_clk) begin
        if (!rstn) begin
            stalled = 1'b0;
        end else begin
            mon_cur = '{bus.push_type, bus.push_addr, bus.push_burst_cnt,
                        bus.push_wt_data, bus.push_wt_mask};
            if (stalled) chk("push_stable", mon_cur, stall_snap);
            if (bus.push_valid && bus.push_ready) got_q.push_back(mon_cur);
            stalled = bus.push_valid && !bus.push_ready;
            if (stalled) begin
                stall_snap = mon_cur;
                chk("wd_ready_stalled", bus.wd_ready, 1'b0);
            end
        end
    end

    task automatic check_reset_vals();
        chk("rst_req_ready",  bus.req_ready, 1'b0);
        chk("rst_wd_ready",   bus.wd_ready, 1'b0);
        chk("rst_push_valid", bus.push_valid, 1'b0);
        chk("rst_push_type",  bus.push_type, 2'd0);
        chk("rst_push_addr",  bus.push_addr, '0);
        chk("rst_push_bc",    bus.push_burst_cnt, '0);
        chk("rst_push_data",  bus.push_wt_data, '0);
        chk("rst_push_mask",  bus.push_wt_mask, 16'hFFFF);
        chk("rst_err_len",    bus.err_len, 1'b0);
    endtask

    task automatic wait_req_ready(input string name);
        int t = 0;
        while (!bus.req_ready && t < 500) begin
            @(posedge wt_clk); #2;
            t++;
        end
        chk(name, bus.req_ready, 1'b1);
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic [MW-1:0] m, input bit last);
        bit ok = 1'b0;
        int t  = 0;
        bus.wd_valid = 1'b1;
        bus.wd_data  = d;
        bus.wd_mask  = m;
        bus.wd_last  = last;
        while (!ok && t < 500) begin
            @(negedge wt_clk);
            ok = bus.wd_ready;
            @(posedge wt_clk); #2;
            t++;
        end
        bus.wd_valid = 1'b0;
        bus.wd_last  = 1'b0;
        if (!ok) chk("wd_handshake_timeout", 1'b0, 1'b1);
    endtask

    task automatic issue_req(input bit wen, input logic [AW-1:0] addr, input logic [BW-1:0] bc);
        wait_req_ready("req_ready_wait");
        bus.req_valid     = 1'b1;
        bus.req_wen       = wen;
        bus.req_addr      = addr;
        bus.req_burst_cnt = bc;
        @(posedge wt_clk); #2;
        bus.req_valid = 1'b0;
        chk("req_ready_after_accept", bus.req_ready, 1'b0);
    endtask

    task automatic run_req(input bit wen, input logic [AW-1:0] addr, input logic [BW-1:0] bc,
                           input logic [DW-1:0] dbase, input int last_at, input bit timing,
                           output int nbeats);
        int c0;
        issue_req(wen, addr, bc);
        if (!wen) begin
            exp_q.push_back('{2'd3, addr, bc, {DW{1'b0}}, {MW{1'b1}}});
            chk("rd_latency", bus.push_valid, 1'b1);
            if (timing) begin
                @(posedge wt_clk); #2;
                chk("rd_req_ready_return", bus.req_ready, 1'b1);
            end
        end else begin
            c0 = cyc_cnt;
            for (int i = 0; i <= int'(bc); i++) begin
                logic [MW-1:0] m;
                m = MW'($urandom);
                exp_q.push_back('{2'd2, model_addr(addr, i), bc, dbase + DW'(i), m});
                send_beat(dbase + DW'(i), m, i == last_at);
                if ((i == last_at) != (i == int'(bc))) err_model = 1'b1;
                chk("wt_latency", bus.push_valid, 1'b1);
                chk("err_len", bus.err_len, err_model);
            end
            if (timing) chk("wt_throughput", cyc_cnt - c0, int'(bc) + 1);
        end
        wait_req_ready("idle_return");
        nbeats = got_q.size();
        chk("beat_count", got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0)
            chk("beat_content", got_q.pop_front(), exp_q.pop_front());
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        int nb;
        bus.req_valid = 0; bus.req_wen = 0; bus.req_addr = '0; bus.req_burst_cnt = '0;
        bus.wd_valid  = 0; bus.wd_data = '0; bus.wd_mask = '0; bus.wd_last = 0;

        vecs[0] = '{1'b0, 27'h100,     6'd7,  7,  0, 1};
        vecs[1] = '{1'b1, 27'h200,     6'd7,  7,  0, 8};
        vecs[2] = '{1'b1, 27'h340,     6'd7,  7,  1, 8};
        vecs[3] = '{1'b1, 27'h010,     6'd0,  0,  0, 1};
        vecs[4] = '{1'b1, 27'h7FFFFF8, 6'd1,  1,  0, 2};
        vecs[5] = '{1'b1, 27'h0ABCDE0, 6'd63, 63, 2, 64};
        vecs[6] = '{1'b0, 27'h5555555, 6'd12, 12, 1, 1};

        repeat (3) @(posedge wt_clk);
        #2;
        check_reset_vals();
        rstn = 1'b1;
        #1;
        chk("req_ready_first_cycle", bus.req_ready, 1'b0);
        @(posedge wt_clk); #2;
        chk("req_ready_after_release", bus.req_ready, 1'b1);

        for (int k = 0; k < 7; k++) begin
            pr_mode  = vecs[k].mode;
            pr_phase = 0;
            run_req(vecs[k].wen, vecs[k].addr, vecs[k].bc, DBASE, vecs[k].last_at,
                    vecs[k].mode == 0, nb);
            chk("vec_beats", nb, vecs[k].exp_beats);
        end

        for (int r = 0; r < 25; r++) begin
            bit            wen;
            logic [BW-1:0] bc;
            pr_mode = $urandom_range(0, 2);
            wen     = $urandom_range(0, 1);
            bc      = ($urandom_range(0, 7) == 0) ? 6'd63 : BW'($urandom_range(0, 15));
            run_req(wen, AW'($urandom), bc, {$urandom, $urandom, $urandom, $urandom},
                    int'(bc), pr_mode == 0, nb);
        end

        // Wrong wd_last on beat 1 of a 4-beat burst; length still follows burst_cnt.
        pr_mode = 0;
        run_req(1'b1, 27'h400, 6'd3, DBASE, 1, 1'b1, nb);
        chk("len_err_beats", nb, 4);
        chk("len_err_sticky", bus.err_len, 1'b1);

        // Reset lands after beat 2 of an 8-beat write.
        issue_req(1'b1, 27'h800, 6'd7);
        for (int i = 0; i < 3; i++) send_beat(DBASE + DW'(i), 16'h00FF, 1'b0);
        #1;
        rstn = 1'b0;
        #1;
        check_reset_vals();
        got_q.delete();
        exp_q.delete();
        err_model = 1'b0;
        repeat (2) @(posedge wt_clk);
        #2;
        rstn = 1'b1;
        repeat (6) @(posedge wt_clk);
        #2;
        chk("no_beats_after_reset", got_q.size(), 0);
        chk("push_idle_after_reset", bus.push_valid, 1'b0);
        run_req(1'b0, 27'h100, 6'd7, DBASE, 7, 1'b1, nb);
        chk("read_after_reset_beats", nb, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
